// File: rtl/nanorv32_periph_fabric_if.sv
// Periph port bundle between the TCM arbiter (master) and the peripheral fabric (slave).
interface nanorv32_periph_fabric_if #(
  parameter int PADDR_W = 12
);
  logic [PADDR_W-1:0] periph_addr;
  logic [3:0]         periph_bytesel;
  logic [31:0]        periph_din;
  logic               periph_en;
  logic [31:0]        periph_dout;
  logic               periph_ready_nxt;

  modport master (
    output periph_addr,
    output periph_bytesel,
    output periph_din,
    output periph_en,
    input  periph_dout,
    input  periph_ready_nxt
  );

  modport slave (
    input  periph_addr,
    input  periph_bytesel,
    input  periph_din,
    input  periph_en,
    output periph_dout,
    output periph_ready_nxt
  );
endinterface

// File: rtl/nanorv32_periph_fabric.sv
// Slot-decoded peripheral interconnect with sticky error termination.
// Optional BUSY timeout: define NANORV32_PERIPH_FABRIC_TIMEOUT_EN.
module nanorv32_periph_fabric #(
  parameter int          NUM_SLAVES = 4,
  parameter int          PADDR_W    = 12,
  parameter int          SLOT_LSB   = 8,
  parameter int          SLOT_BITS  = 2,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nanorv32_periph_fabric_if.slave periph,
  output logic [PADDR_W-1:0]      bus_slv_addr,
  output logic [3:0]              bus_slv_bytesel,
  output logic [31:0]             bus_slv_din,
  output logic [NUM_SLAVES-1:0]   bus_slv_en,
  input  logic [32*NUM_SLAVES-1:0] slv_bus_dout,
  input  logic [NUM_SLAVES-1:0]   slv_bus_ready_nxt,
  input  logic                    err_clr,
  output logic                    bus_err,
  output logic [PADDR_W-1:0]      bus_err_addr
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t               state;
  logic [SLOT_BITS-1:0] slot_q;
  logic [SLOT_BITS-1:0] sel;
  logic [SLOT_BITS-1:0] act;
  logic                 err_q;
  logic                 mapped;
  logic                 slv_rdy;
  logic                 timeout_hit;
  logic                 err_term;
  logic                 en;

  assign en  = periph.periph_en;
  assign sel = periph.periph_addr[SLOT_LSB +: SLOT_BITS];
  assign act = (state == IDLE) ? sel : slot_q;

  assign mapped = int'(act) < NUM_SLAVES;

  assign bus_slv_addr    = periph.periph_addr;
  assign bus_slv_bytesel = periph.periph_bytesel;
  assign bus_slv_din     = periph.periph_din;

  always_comb begin
    slv_rdy = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (act == SLOT_BITS'(i)) begin
        slv_rdy = slv_bus_ready_nxt[i];
      end
    end
  end

`ifdef NANORV32_PERIPH_FABRIC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] timer;

  // A slave answering on the last allowed cycle still wins.
  assign timeout_hit = (state == BUSY) && en && !slv_rdy &&
                       (timer == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    bus_slv_en = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      bus_slv_en[i] = en && mapped && !timeout_hit &&
                      (act == SLOT_BITS'(i));
    end
  end

  assign err_term = en && (!mapped || timeout_hit);

  assign periph.periph_ready_nxt =
    en && (!mapped || slv_rdy || timeout_hit);

  always_comb begin
    periph.periph_dout = slv_bus_dout[31:0];
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slot_q == SLOT_BITS'(i)) begin
        periph.periph_dout = slv_bus_dout[32*i +: 32];
      end
    end
    if (err_q) begin
      periph.periph_dout = ERR_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      slot_q       <= '0;
      err_q        <= 1'b0;
      bus_err      <= 1'b0;
      bus_err_addr <= '0;
`ifdef NANORV32_PERIPH_FABRIC_TIMEOUT_EN
      timer        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            if (!mapped) begin
              err_q <= 1'b1;
            end else begin
              slot_q <= sel;
              err_q  <= 1'b0;
              if (!slv_rdy) begin
                state <= BUSY;
`ifdef NANORV32_PERIPH_FABRIC_TIMEOUT_EN
                timer <= TW'(1);
`endif
              end
            end
          end
        end
        BUSY: begin
          if (!en || slv_rdy) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            state <= IDLE;
            err_q <= 1'b1;
          end else begin
`ifdef NANORV32_PERIPH_FABRIC_TIMEOUT_EN
            timer <= timer + 1'b1;
`endif
          end
        end
      endcase

      // A clear coinciding with a new error re-arms capture.
      if (err_term) begin
        bus_err <= 1'b1;
        if (!bus_err || err_clr) begin
          bus_err_addr <= periph.periph_addr;
        end
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nanorv32_periph_fabric.sv
// Randomised bench for nanorv32_periph_fabric against a transaction-level model.
module tb_nanorv32_periph_fabric;
  localparam int NS = 3;
  localparam int AW = 12;
  localparam int TO = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nanorv32_periph_fabric_if #(.PADDR_W(AW)) periph ();

  logic [AW-1:0]   bus_slv_addr;
  logic [3:0]      bus_slv_bytesel;
  logic [31:0]     bus_slv_din;
  logic [NS-1:0]   bus_slv_en;
  logic [32*NS-1:0] slv_bus_dout;
  logic [NS-1:0]   slv_bus_ready_nxt;
  logic            err_clr;
  logic            bus_err;
  logic [AW-1:0]   bus_err_addr;

  nanorv32_periph_fabric #(
    .NUM_SLAVES(NS), .PADDR_W(AW), .SLOT_LSB(8),
    .SLOT_BITS(2), .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .periph(periph),
    .bus_slv_addr(bus_slv_addr), .bus_slv_bytesel(bus_slv_bytesel),
    .bus_slv_din(bus_slv_din), .bus_slv_en(bus_slv_en),
    .slv_bus_dout(slv_bus_dout), .slv_bus_ready_nxt(slv_bus_ready_nxt),
    .err_clr(err_clr), .bus_err(bus_err), .bus_err_addr(bus_err_addr)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] sdata [NS];
  logic          m_err = 1'b0;
  logic [AW-1:0] m_eaddr = '0;
  logic          p_err = 1'b0;
  logic          p_clr = 1'b0;
  logic [AW-1:0] p_addr = '0;

  logic          cmp_on = 1'b0;
  logic [NS-1:0] x_en;
  logic          x_rdy;
  logic          x_err;
  logic [AW-1:0] x_eaddr;
  logic          x_dv;
  logic [31:0]   x_dout;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("slv_en", 32'(bus_slv_en), 32'(x_en));
      chk("ready_nxt", 32'(periph.periph_ready_nxt), 32'(x_rdy));
      chk("bus_err", 32'(bus_err), 32'(x_err));
      chk("bus_err_addr", 32'(bus_err_addr), 32'(x_eaddr));
      chk("bc_addr", 32'(bus_slv_addr), 32'(periph.periph_addr));
      chk("bc_bytesel", 32'(bus_slv_bytesel), 32'(periph.periph_bytesel));
      chk("bc_din", bus_slv_din, periph.periph_din);
      if (x_dv) chk("dout", periph.periph_dout, x_dout);
    end
  end

  task automatic drive_sdata();
    for (int j = 0; j < NS; j++) slv_bus_dout[32*j +: 32] = sdata[j];
  endtask

  // One clock of stimulus plus the outputs the model expects for it.
  task automatic cyc(input logic en, input logic [AW-1:0] a,
                     input logic [NS-1:0] rdy, input logic clr,
                     input logic [NS-1:0] e_en, input logic e_rdy,
                     input logic e_err, input logic dv,
                     input logic [31:0] de);
    @(posedge clk);
    #1;
    if (p_err) begin
      if (!m_err || p_clr) m_eaddr = p_addr;
      m_err = 1'b1;
    end else if (p_clr) begin
      m_err = 1'b0;
    end
    periph.periph_en      = en;
    periph.periph_addr    = a;
    periph.periph_bytesel = 4'($urandom);
    periph.periph_din     = $urandom;
    slv_bus_ready_nxt     = rdy;
    err_clr               = clr;
    drive_sdata();
    x_en = e_en; x_rdy = e_rdy; x_dv = dv; x_dout = de;
    x_err = m_err; x_eaddr = m_eaddr;
    p_err = e_err; p_clr = clr; p_addr = a;
    cmp_on = 1'b1;
  endtask

  task automatic txn(input logic [AW-1:0] a, input int w, input bit tog,
                     input bit clr_end, output logic [31:0] exp_d);
    int s;
    int k;
    bit done;
    logic [NS-1:0] rdy;
    logic [NS-1:0] oh;
    logic [AW-1:0] ca;
    s = int'(a[9:8]);
    k = 0;
    done = 0;
    ca = a;
    oh = '0;
    if (s < NS) oh[s] = 1'b1;
    exp_d = ERRD;
    while (!done) begin
      rdy = NS'($urandom);
      if (s < NS) rdy[s] = (k == w);
      if (s >= NS) begin
        cyc(1, ca, rdy, clr_end, '0, 1, 1, 0, 0);
        exp_d = ERRD;
        done = 1;
      end else if (k == w) begin
        cyc(1, ca, rdy, 0, oh, 1, 0, 0, 0);
        exp_d = sdata[s];
        done = 1;
`ifdef NANORV32_PERIPH_FABRIC_TIMEOUT_EN
      end else if (k == TO - 1) begin
        cyc(1, ca, rdy, clr_end, '0, 1, 1, 0, 0);
        exp_d = ERRD;
        done = 1;
`endif
      end else begin
        cyc(1, ca, rdy, 0, oh, 0, 0, 0, 0);
      end
      k++;
      if (tog) ca = AW'($urandom);
    end
  endtask

  task automatic run(input logic [AW-1:0] a, input int w, input bit tog,
                     input bit clr_end, input bit clr_idle);
    logic [31:0] d;
    txn(a, w, tog, clr_end, d);
    cyc(0, AW'($urandom), NS'($urandom), clr_idle, '0, 0, 0, 1, d);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input bit clr);
    cyc(0, AW'($urandom), NS'($urandom), clr, '0, 0, 0, 0, 0);
  endtask

  initial begin
    int w;
    logic [AW-1:0] a;
    bit tog;
    sdata[0] = 32'h0000_AA00;
    sdata[1] = 32'h1111_0001;
    sdata[2] = 32'h2222_0002;
    drive_sdata();
    periph.periph_en = 0; periph.periph_addr = '0;
    periph.periph_bytesel = '0; periph.periph_din = '0;
    slv_bus_ready_nxt = '0; err_clr = 0;
    x_en = '0; x_rdy = 0; x_err = 0; x_eaddr = '0;
    x_dv = 1; x_dout = sdata[0];
    cmp_on = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_dout_lit", periph.periph_dout, 32'h0000_AA00);
    rst_n = 1'b1;

    run(12'h104, 0, 0, 0, 0);
    chk("s1_read_lit", periph.periph_dout, 32'h1111_0001);
    run(12'h208, 3, 1, 0, 0);
    chk("s2_wait_lit", periph.periph_dout, 32'h2222_0002);
    chk("s2_noerr_lit", 32'(bus_err), 32'd0);
    run(12'h3F0, 0, 0, 0, 0);
    chk("unmap_dout_lit", periph.periph_dout, 32'hDEAD_BEEF);
    chk("unmap_err_lit", 32'(bus_err), 32'd1);
    chk("unmap_addr_lit", 32'(bus_err_addr), 32'h3F0);
    run(12'h3C4, 0, 0, 0, 1);
    chk("first_kept_lit", 32'(bus_err_addr), 32'h3F0);
    idle(0);
    @(negedge clk);
    #1;
    chk("clr_flag_lit", 32'(bus_err), 32'd0);
    run(12'h300, 0, 0, 0, 0);
    run(12'h3A8, 0, 0, 1, 0);
    chk("clr_vs_err_lit", 32'(bus_err_addr), 32'h3A8);
    chk("clr_vs_err_flag", 32'(bus_err), 32'd1);
    idle(1);
`ifdef NANORV32_PERIPH_FABRIC_TIMEOUT_EN
    run(12'h010, 100, 0, 0, 0);
    chk("timeout_dout_lit", periph.periph_dout, 32'hDEAD_BEEF);
    chk("timeout_addr_lit", 32'(bus_err_addr), 32'h010);
    idle(1);
    run(12'h020, TO - 1, 0, 0, 0);
    chk("late_ready_lit", periph.periph_dout, 32'h0000_AA00);
`endif

    // Reset while a slave is stalling the transfer.
    cyc(1, 12'h208, '0, 0, 3'b100, 0, 0, 0, 0);
    cyc(1, 12'h208, '0, 0, 3'b100, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    periph.periph_en = 0;
    slv_bus_ready_nxt = '0;
    err_clr = 0;
    m_err = 0; m_eaddr = '0; p_err = 0; p_clr = 0;
    x_en = '0; x_rdy = 0; x_err = 0; x_eaddr = '0;
    x_dv = 1; x_dout = sdata[0];
    @(negedge clk);
    #1;
    chk("rst_en_lit", 32'(bus_slv_en), 32'd0);
    rst_n = 1'b1;
    run(12'h1FC, 1, 0, 0, 0);
    chk("post_rst_lit", periph.periph_dout, 32'h1111_0001);

    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < NS; j++) sdata[j] = $urandom;
      a = AW'($urandom);
      w = $urandom_range(0, 5);
      tog = 1'($urandom);
`ifdef NANORV32_PERIPH_FABRIC_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) begin
        w = $urandom_range(TO - 1, 40);
        tog = 0;
      end
`endif
      run(a, w, tog, 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0));
    end

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
